// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes bytes from a valid/ready stream and shifts them
// onto an idle-high serial line as start / 5-8 data / optional parity / 1-2 stop bits.
module uart_tx_serializer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_data_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop2_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic [1:0]           nbits_q, nbits_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;

  logic                 bit_end;
  logic                 last_stop;
  logic                 last_data;
  logic                 ready;
  logic                 accept;

  assign div_eff   = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign bit_end   = (cnt_q == div_eff - DIV_WIDTH'(1));
  assign last_data = (bit_q == ({1'b0, nbits_q} + 3'd4));
  // Ready in the final clock of the last stop bit lets frames run back-to-back.
  assign last_stop = (state_q == STOP) && bit_end && (!stop2_q || stop_q);
  assign ready     = (state_q == IDLE) || last_stop;

  assign tx_ready_o = ready & arst_ni;
  assign accept     = tx_valid_i & tx_ready_o;
  assign busy_o     = (state_q != IDLE);
  assign tx_o       = tx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    div_d     = div_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_d     = par_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          bit_d   = bit_q + 3'd1;
          if (last_data) begin
            state_d = par_en_q ? PARITY : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake only happens in IDLE or the last stop clock; both start a new frame.
    if (accept) begin
      state_d   = START;
      cnt_d     = '0;
      bit_d     = 3'd0;
      stop_d    = 1'b0;
      shift_d   = tx_data_i;
      par_d     = 1'b0;
      div_d     = cfg_div_i;
      nbits_d   = cfg_data_bits_i;
      par_en_d  = cfg_parity_en_i;
      par_odd_d = cfg_parity_odd_i;
      stop2_d   = cfg_stop2_i;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ par_odd_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= 3'd0;
      stop_q    <= 1'b0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      nbits_q   <= 2'd0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level line model checked every clock,
// plus directed frames whose lengths and bit patterns are pinned by hand.
module tb_uart_tx_serializer;

  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic [DW-1:0] cfg_div_i = '0;
  logic [1:0]    cfg_data_bits_i = 2'd0;
  logic          cfg_parity_en_i = 1'b0;
  logic          cfg_parity_odd_i = 1'b0;
  logic          cfg_stop2_i = 1'b0;
  logic [7:0]    tx_data_i = 8'h00;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic          tx_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  bit model_ready = 1'b0;

  uart_tx_serializer #(.DIV_WIDTH(DW)) dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .cfg_div_i       (cfg_div_i),
    .cfg_data_bits_i (cfg_data_bits_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_parity_odd_i(cfg_parity_odd_i),
    .cfg_stop2_i     (cfg_stop2_i),
    .tx_data_i       (tx_data_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .tx_o            (tx_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expands one byte into the per-clock line levels of its whole frame.
  function automatic void push_frame(input logic [7:0] data, input int div, input int nb,
                                     input bit pe, input bit po, input bit s2);
    int d;
    int n;
    bit p;
    bit line[$];
    d = (div == 0) ? 1 : div;
    n = 5 + nb;
    p = po;
    line.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      line.push_back(data[i]);
      p = p ^ data[i];
    end
    if (pe) line.push_back(p);
    line.push_back(1'b1);
    if (s2) line.push_back(1'b1);
    foreach (line[k]) begin
      for (int r = 0; r < d; r++) exp_q.push_back(line[k]);
    end
  endfunction

  always @(negedge clk_i) begin : compare
    bit e;
    if (!arst_ni) begin
      model_ready = 1'b0;
      exp_q.delete();
      check_output("rst_tx", tx_o, 1);
      check_output("rst_busy", busy_o, 0);
      check_output("rst_ready", tx_ready_o, 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      model_ready = (exp_q.size() == 0);
      check_output("line_tx", tx_o, e);
      check_output("line_busy", busy_o, 1);
      check_output("line_ready", tx_ready_o, model_ready);
    end else begin
      model_ready = 1'b1;
      check_output("idle_tx", tx_o, 1);
      check_output("idle_busy", busy_o, 0);
      check_output("idle_ready", tx_ready_o, 1);
    end
    if (arst_ni && tx_valid_i && model_ready)
      push_frame(tx_data_i, int'(cfg_div_i), int'(cfg_data_bits_i),
                 cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i);
  end

  task automatic apply_stimulus(input logic [7:0] data, input int div, input int nb,
                                input bit pe, input bit po, input bit s2);
    @(posedge clk_i);
    #1;
    cfg_div_i        = DW'(div);
    cfg_data_bits_i  = 2'(nb);
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
    tx_data_i        = data;
    tx_valid_i       = 1'b1;
  endtask

  task automatic wait_handshake(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (tx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("hs_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [7:0] data, input int div, input int nb,
                           input bit pe, input bit po, input bit s2,
                           input int exp_len, input int exp_rlow, input int exp_nbit,
                           input logic [11:0] exp_bits, input string tag);
    bit ok;
    bit samp[$];
    int len;
    int rlow;
    int d;
    logic [11:0] got;
    apply_stimulus(data, div, nb, pe, po, s2);
    wait_handshake(ok);
    if (!ok) return;
    @(posedge clk_i);
    #1;
    tx_valid_i = 1'b0;
    len = 0;
    rlow = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      if (!busy_o) break;
      samp.push_back(tx_o);
      if (!tx_ready_o) rlow++;
      len++;
    end
    check_output({tag, "_len"}, len, exp_len);
    check_output({tag, "_ready_low"}, rlow, exp_rlow);
    d = (div == 0) ? 1 : div;
    got = '0;
    for (int b = 0; b < exp_nbit; b++) begin
      if (b * d < samp.size()) got[b] = samp[b * d];
    end
    check_output({tag, "_bits"}, got, exp_bits);
  endtask

  initial begin : stimulus
    bit ok;
    bit drop;
    int len;
    int hs;
    logic [19:0] got20;

    repeat (3) @(negedge clk_i);
    check_output("reset_ready_low", tx_ready_o, 0);
    check_output("reset_tx_high", tx_o, 1);
    #2;
    arst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check_output("idle_ready_after_reset", tx_ready_o, 1);
    check_output("idle_busy_after_reset", busy_o, 0);

    run_frame(8'hA5, 4, 3, 1'b0, 1'b0, 1'b0, 40, 39, 10, 12'h34A, "a5_8n1");
    run_frame(8'hFF, 2, 2, 1'b1, 1'b0, 1'b0, 20, 19, 10, 12'h3FE, "ff_7e1");
    run_frame(8'h03, 3, 0, 1'b1, 1'b1, 1'b1, 27, 26, 9, 12'h1C6, "03_5o2");

    // Two bytes with valid held: second start bit directly after first stop bit.
    apply_stimulus(8'h55, 1, 3, 1'b0, 1'b0, 1'b0);
    wait_handshake(ok);
    hs = ok ? 1 : 0;
    @(posedge clk_i);
    #1;
    tx_data_i = 8'h0F;
    len = 0;
    drop = 1'b0;
    got20 = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (!busy_o) break;
      if (len < 20) got20[len] = tx_o;
      len++;
      if (tx_valid_i && tx_ready_o) begin
        hs++;
        drop = 1'b1;
      end
      @(posedge clk_i);
      #1;
      if (drop) tx_valid_i = 1'b0;
    end
    tx_valid_i = 1'b0;
    check_output("b2b_len", len, 20);
    check_output("b2b_handshakes", hs, 2);
    check_output("b2b_bits", got20, 20'h87AAA);

    // Abort mid-DATA of an all-zero byte, then send a clean frame.
    apply_stimulus(8'h00, 4, 3, 1'b0, 1'b0, 1'b0);
    wait_handshake(ok);
    @(posedge clk_i);
    #1;
    tx_valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check_output("pre_abort_tx_low", tx_o, 0);
    #2;
    arst_ni = 1'b0;
    #1;
    check_output("abort_tx_high", tx_o, 1);
    check_output("abort_busy", busy_o, 0);
    check_output("abort_ready", tx_ready_o, 0);
    repeat (2) @(negedge clk_i);
    #2;
    arst_ni = 1'b1;
    run_frame(8'h3C, 4, 3, 1'b0, 1'b0, 1'b0, 40, 39, 10, 12'h278, "after_abort");

    run_frame(8'hA5, 0, 3, 1'b0, 1'b0, 1'b0, 10, 9, 10, 12'h34A, "div0");
    run_frame(8'hA5, 1, 3, 1'b0, 1'b0, 1'b0, 10, 9, 10, 12'h34A, "div1");

    repeat (5) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
